// File: rtl/mxv_fifo_arbiter.sv
// Two-requester burst arbiter feeding a FIFO push port, with occupancy tracking.
// Optional sticky error output enabled by defining MXV_ARB_ERR_FLAG_EN.
module mxv_fifo_arbiter #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int LVL_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    input  logic                  pop_req,
    output logic                  push_en,
    output logic [DATA_WIDTH-1:0] push_data,
    output logic                  pop_en,
    output logic [LVL_WIDTH-1:0]  level,
`ifdef MXV_ARB_ERR_FLAG_EN
    output logic                  err,
`endif
    output logic                  full,
    output logic                  empty
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOCK_A = 2'd1,
        S_LOCK_B = 2'd2
    } state_t;

    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_burst;
    logic [3:0]              w_burst_nxt;
    logic                    r_last;
    logic                    w_last_nxt;
    logic                    w_sel_a;
    logic                    w_sel_b;
    logic                    w_idle_rule;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    r_push_en;
    logic [DATA_WIDTH-1:0]   r_push_data;
    logic                    r_pop_en;
    logic [LVL_WIDTH-1:0]    r_level;

    assign w_full  = (r_level == LVL_WIDTH'(DEPTH));
    assign w_empty = (r_level == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_burst <= '0;
            r_last  <= LAST_B;
        end else begin
            r_state <= w_state_nxt;
            r_burst <= w_burst_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Leaving a lock hands over to the IDLE rule in the same cycle, so
    // a waiting requester is granted without a bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst;
        w_last_nxt  = r_last;
        w_sel_a     = 1'b0;
        w_sel_b     = 1'b0;
        w_idle_rule = 1'b0;
        case (r_state)
            S_LOCK_A: begin
                if (!w_full) begin
                    if (req_a && (r_burst < 4'(BURST_LEN))) begin
                        w_sel_a     = 1'b1;
                        w_burst_nxt = r_burst + 4'd1;
                    end else begin
                        w_last_nxt  = LAST_A;
                        w_idle_rule = 1'b1;
                    end
                end
            end
            S_LOCK_B: begin
                if (!w_full) begin
                    if (req_b && (r_burst < 4'(BURST_LEN))) begin
                        w_sel_b     = 1'b1;
                        w_burst_nxt = r_burst + 4'd1;
                    end else begin
                        w_last_nxt  = LAST_B;
                        w_idle_rule = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idle_rule = !w_full;
            end
        endcase
        if (w_idle_rule) begin
            if (req_a && (!req_b || (w_last_nxt == LAST_B))) begin
                w_sel_a     = 1'b1;
                w_state_nxt = S_LOCK_A;
                w_burst_nxt = 4'd1;
            end else if (req_b) begin
                w_sel_b     = 1'b1;
                w_state_nxt = S_LOCK_B;
                w_burst_nxt = 4'd1;
            end else begin
                w_state_nxt = S_IDLE;
                w_burst_nxt = 4'd0;
            end
        end
    end

    always_comb begin
        gnt_a = w_sel_a & ~reset;
        gnt_b = w_sel_b & ~reset;
    end

    assign w_push = gnt_a | gnt_b;
    assign w_pop  = pop_req & ~w_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_push_en   <= 1'b0;
            r_push_data <= '0;
            r_pop_en    <= 1'b0;
            r_level     <= '0;
        end else begin
            r_push_en <= w_push;
            r_pop_en  <= w_pop;
            if (w_push) begin
                r_push_data <= gnt_a ? data_a : data_b;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_WIDTH'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_WIDTH'(1);
            end
        end
    end

`ifdef MXV_ARB_ERR_FLAG_EN
    logic r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((pop_req && w_empty) || ((req_a || req_b) && w_full)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

    assign push_en   = r_push_en;
    assign push_data = r_push_data;
    assign pop_en    = r_pop_en;
    assign level     = r_level;
    assign full      = w_full;
    assign empty     = w_empty;

endmodule

// File: tb/tb_mxv_fifo_arbiter.sv
// Randomized self-checking bench for mxv_fifo_arbiter against a rule-level model.
// Error-flag checks are compiled in when MXV_ARB_ERR_FLAG_EN is defined.
module tb_mxv_fifo_arbiter;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int BL    = 4;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_a, req_b, pop_req;
    logic [DW-1:0] data_a, data_b;
    logic          gnt_a, gnt_b;
    logic          push_en, pop_en, full, empty;
    logic [DW-1:0] push_data;
    logic [LW-1:0] level;
`ifdef MXV_ARB_ERR_FLAG_EN
    logic          err;
`endif

    mxv_fifo_arbiter #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .BURST_LEN(BL), .LVL_WIDTH(LW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .req_b(req_b),
        .data_a(data_a), .data_b(data_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .pop_req(pop_req),
        .push_en(push_en), .push_data(push_data),
        .pop_en(pop_en), .level(level),
`ifdef MXV_ARB_ERR_FLAG_EN
        .err(err),
`endif
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: owner 0=none 1=A 2=B; run = grants in current burst; last served.
    int            m_owner, m_run, m_last, m_level;
    logic          e_ga, e_gb, e_push_en, e_pop_en, e_err;
    logic [DW-1:0] e_push_data;
    logic          o_ga, o_gb;

    wire [DW+LW+3:0] w_obs = {push_en, push_data, pop_en, level, full, empty};

    function automatic logic [DW+LW+3:0] exp_vec();
        return {e_push_en, e_push_data, e_pop_en, LW'(m_level),
                m_level == DEPTH, m_level == 0};
    endfunction

    task automatic model_reset();
        m_owner = 0; m_run = 0; m_last = 2; m_level = 0;
        e_ga = 0; e_gb = 0; e_push_en = 0; e_pop_en = 0;
        e_push_data = '0; e_err = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_a = 0; req_b = 0; pop_req = 0;
        data_a = '0; data_b = '0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drive_cycle(input logic ra, input logic rb, input logic pr);
        int  pick;
        bit  popok;
        req_a = ra; req_b = rb; pop_req = pr;
        data_a = DW'($urandom); data_b = DW'($urandom);
        #3;
        o_ga = gnt_a; o_gb = gnt_b;
        pick = 0;
        if (m_level < DEPTH) begin
            if (m_owner == 1 && ra && m_run < BL) pick = 1;
            if (m_owner == 2 && rb && m_run < BL) pick = 2;
            if (pick != 0) begin
                m_run++;
            end else begin
                if (m_owner != 0) m_last = m_owner;
                if (ra && rb)  pick = (m_last == 1) ? 2 : 1;
                else if (ra)   pick = 1;
                else if (rb)   pick = 2;
                m_owner = pick;
                m_run   = (pick != 0) ? 1 : 0;
            end
        end
        popok = pr && (m_level > 0);
        if ((pr && m_level == 0) || ((ra || rb) && m_level == DEPTH)) e_err = 1;
        e_ga = (pick == 1); e_gb = (pick == 2);
        e_push_en = (pick != 0);
        if (pick == 1) e_push_data = data_a;
        if (pick == 2) e_push_data = data_b;
        e_pop_en = popok;
        m_level = m_level + int'(pick != 0) - int'(popok);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_a = 1; req_b = 1; pop_req = 1;
        data_a = 8'hA5; data_b = 8'h5A;
        #2;
        n_total++;
        if ({gnt_a, gnt_b} !== 2'b00) $display("FAIL reset_gnt got %b%b exp 00", gnt_a, gnt_b);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (w_obs !== {1'b0, {DW{1'b0}}, 1'b0, {LW{1'b0}}, 1'b0, 1'b1})
            $display("FAIL reset_outs got %h exp empty-only", w_obs);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_single_a();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(i < 3, 1'b0, 1'b0);
            n_total++;
            if ({o_ga, o_gb} !== {e_ga, e_gb})
                $display("FAIL single_a_gnt c%0d got %b%b exp %b%b", i, o_ga, o_gb, e_ga, e_gb);
            else n_pass++;
            n_total++;
            if (w_obs !== exp_vec())
                $display("FAIL single_a_outs c%0d got %h exp %h", i, w_obs, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (level !== 4'd3) $display("FAIL single_a_level got %0d exp 3", level);
        else n_pass++;
    endtask

    task automatic test_burst();
        string seq = "";
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b1);
            seq = {seq, o_ga ? "A" : (o_gb ? "B" : "-")};
            n_total++;
            if (w_obs !== exp_vec())
                $display("FAIL burst_outs c%0d got %h exp %h", i, w_obs, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (seq != "AAAABBBBAAAA") $display("FAIL burst_pattern got %s exp AAAABBBBAAAA", seq);
        else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0);
            n_total++;
            if ({o_gb, level, full} !== {1'b0, 4'd8, 1'b1})
                $display("FAIL full_hold c%0d got gnt_b=%b lvl=%0d exp 0/8", i, o_gb, level);
            else n_pass++;
        end
        drive_cycle(1'b0, 1'b1, 1'b1);
        n_total++;
        if ({o_gb, pop_en, level} !== {1'b0, 1'b1, 4'd7})
            $display("FAIL full_pop got gnt_b=%b pop_en=%b lvl=%0d exp 0/1/7", o_gb, pop_en, level);
        else n_pass++;
        drive_cycle(1'b0, 1'b1, 1'b0);
        n_total++;
        if ({o_gb, push_en, push_data, level} !== {1'b1, 1'b1, e_push_data, 4'd8})
            $display("FAIL full_regrant got gnt_b=%b push=%b lvl=%0d exp 1/1/8", o_gb, push_en, level);
        else n_pass++;
    endtask

    task automatic test_empty_pop();
        do_reset();
        drive_cycle(1'b1, 1'b0, 1'b1);
        n_total++;
        if ({o_ga, level, pop_en, push_en} !== {1'b1, 4'd1, 1'b0, 1'b1})
            $display("FAIL empty_pop got gnt_a=%b lvl=%0d pop_en=%b exp 1/1/0", o_ga, level, pop_en);
        else n_pass++;
    endtask

    task automatic test_push_pop();
        do_reset();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b1);
        n_total++;
        if ({o_ga, level, push_en, pop_en} !== {1'b1, 4'd5, 1'b1, 1'b1})
            $display("FAIL push_pop got gnt_a=%b lvl=%0d push=%b pop=%b exp 1/5/1/1",
                     o_ga, level, push_en, pop_en);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                        (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1));
            n_total++;
            if ({o_ga, o_gb} !== {e_ga, e_gb})
                $display("FAIL rand_gnt c%0d got %b%b exp %b%b", i, o_ga, o_gb, e_ga, e_gb);
            else n_pass++;
            n_total++;
            if (w_obs !== exp_vec())
                $display("FAIL rand_outs c%0d got %h exp %h", i, w_obs, exp_vec());
            else n_pass++;
`ifdef MXV_ARB_ERR_FLAG_EN
            n_total++;
            if (err !== e_err) $display("FAIL rand_err c%0d got %b exp %b", i, err, e_err);
            else n_pass++;
`endif
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_cycle(1'b1, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if ({gnt_a, gnt_b, w_obs} !== {2'b00, 1'b0, {DW{1'b0}}, 1'b0, {LW{1'b0}}, 1'b0, 1'b1})
            $display("FAIL reset_mid_async got %b%b %h exp all clear", gnt_a, gnt_b, w_obs);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        drive_cycle(1'b0, 1'b0, 1'b0);
        n_total++;
        if ({push_en, pop_en, level} !== {1'b0, 1'b0, 4'd0})
            $display("FAIL reset_mid_release got push=%b pop=%b lvl=%0d exp 0/0/0",
                     push_en, pop_en, level);
        else n_pass++;
    endtask

`ifdef MXV_ARB_ERR_FLAG_EN
    task automatic test_err();
        do_reset();
        drive_cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (err !== 1'b1) $display("FAIL err_sticky c%0d got %b exp 1", i, err);
            else n_pass++;
            drive_cycle(1'b1, 1'b0, 1'b0);
        end
        reset = 1'b1;
        #1;
        n_total++;
        if ({err, push_en, pop_en, level} !== {1'b0, 1'b0, 1'b0, 4'd0})
            $display("FAIL err_reset got err=%b push=%b pop=%b exp 0", err, push_en, pop_en);
        else n_pass++;
        do_reset();
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_single_a();
        test_burst();
        test_full();
        test_empty_pop();
        test_push_pop();
        test_random();
        test_reset_mid();
`ifdef MXV_ARB_ERR_FLAG_EN
        test_err();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
